// File: rtl/matrix_scan_ctrl.sv
// Column-multiplexed 5x7 LED matrix driver showing a double-buffered 2-of-5 code word.
// Build option: define MATRIX_SCAN_BLANK_EN to insert an all-off BLANK state between columns.
module matrix_scan_ctrl #(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [4:0] code_in,
    output logic [4:0] col_n,
    output logic [6:0] row,
    output logic       code_err,
    output logic       frame_done
);

    localparam int unsigned MaxDwell = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CntW     = $clog2(MaxDwell) + 1;
    localparam logic [CntW-1:0] ScanLast = CntW'(PRESCALE - 1);
`ifdef MATRIX_SCAN_BLANK_EN
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
`endif
    localparam logic [3:0] SymErr = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StScan
`ifdef MATRIX_SCAN_BLANK_EN
        , StBlank
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      col_q, col_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            loaded_q, loaded_d;
    logic [4:0]      back_q, back_d;
    logic [4:0]      front_q, front_d;
    logic [4:0]      col_n_q, col_n_d;
    logic [6:0]      row_q, row_d;
    logic            code_err_q, code_err_d;
    logic            frame_done_q, frame_done_d;
    logic [2:0]      next_col;
    logic            boundary;
    logic [3:0]      sym_d;

    function automatic logic [3:0] decode(input logic [4:0] c);
        case (c)
            5'b11000: decode = 4'd0;
            5'b00011: decode = 4'd1;
            5'b00101: decode = 4'd2;
            5'b00110: decode = 4'd3;
            5'b01001: decode = 4'd4;
            5'b01010: decode = 4'd5;
            5'b01100: decode = 4'd6;
            5'b10001: decode = 4'd7;
            5'b10010: decode = 4'd8;
            5'b10100: decode = 4'd9;
            default:  decode = SymErr;
        endcase
    endfunction

    // Glyph words packed leftmost column in the MSBs; bit0 of each column is the top row.
    function automatic logic [6:0] glyph(input logic [3:0] sym, input logic [2:0] col);
        logic [34:0] g;
        case (sym)
            4'd0:    g = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            4'd1:    g = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            4'd2:    g = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            4'd3:    g = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            4'd4:    g = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            4'd5:    g = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            4'd6:    g = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            4'd7:    g = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            4'd8:    g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            4'd9:    g = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            default: g = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
        endcase
        return g[(4 - int'(col)) * 7 +: 7];
    endfunction

    always_comb begin
        loaded_d = loaded_q | load;
        back_d   = load ? code_in : back_q;
        next_col = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
        boundary = (state_q == StScan) && (col_q == 3'd4) && (cnt_q == ScanLast);
        // A load on the boundary cycle is forwarded straight into the front buffer.
        front_d  = ((state_q == StIdle) || boundary) ? back_d : front_q;

        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q + CntW'(1);
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable && loaded_d) begin
                    state_d = StScan;
                    col_d   = 3'd0;
                end
            end
            StScan: begin
                if (cnt_q == ScanLast) begin
                    cnt_d = '0;
`ifdef MATRIX_SCAN_BLANK_EN
                    state_d = StBlank;
`else
                    col_d = next_col;
`endif
                end
            end
`ifdef MATRIX_SCAN_BLANK_EN
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    cnt_d   = '0;
                    state_d = StScan;
                    col_d   = next_col;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
        end

        // Outputs are precomputed from next state so they leave the chip straight from flops.
        sym_d   = decode(front_d);
        col_n_d = 5'b11111;
        row_d   = '0;
        if (state_d == StScan) begin
            col_n_d = ~(5'b00001 << col_d);
            row_d   = glyph(sym_d, col_d);
        end
        frame_done_d = (state_d == StScan) && (col_d == 3'd4) && (cnt_d == ScanLast);
        // Nothing is displayed before the first load, so the all-zero reset code is not flagged.
        code_err_d   = loaded_d && (sym_d == SymErr);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            col_q        <= 3'd0;
            cnt_q        <= '0;
            loaded_q     <= 1'b0;
            back_q       <= 5'b00000;
            front_q      <= 5'b00000;
            col_n_q      <= 5'b11111;
            row_q        <= 7'b0000000;
            code_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            loaded_q     <= loaded_d;
            back_q       <= back_d;
            front_q      <= front_d;
            col_n_q      <= col_n_d;
            row_q        <= row_d;
            code_err_q   <= code_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign col_n      = col_n_q;
    assign row        = row_q;
    assign code_err   = code_err_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: a table of code words plus hand-built multi-cycle sequences,
// with per-cycle expected outputs queued as stimulus is driven and checked on the falling edge.
`timescale 1ns/1ps
module tb_matrix_scan_ctrl;

`ifdef MATRIX_SCAN_BLANK_EN
    localparam int P = 2;
    localparam int B = 1;
`else
    localparam int P = 3;
    localparam int B = 0;
`endif
    localparam int CP = P + B;
    localparam int FL = 5 * CP;
    localparam int FD = 4 * CP + P - 1;

    localparam logic [34:0] G0 = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
    localparam logic [34:0] G1 = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
    localparam logic [34:0] G2 = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
    localparam logic [34:0] G3 = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
    localparam logic [34:0] G4 = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
    localparam logic [34:0] G5 = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
    localparam logic [34:0] G6 = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
    localparam logic [34:0] G7 = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
    localparam logic [34:0] G8 = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
    localparam logic [34:0] G9 = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
    localparam logic [34:0] GE = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};

    typedef struct {
        logic [4:0] col_n;
        logic [6:0] row;
        logic       err;
        logic       fd;
        string      tag;
    } exp_t;

    typedef struct {
        logic [4:0]  code;
        logic [34:0] glyph;
        logic        err;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [4:0] code_in;
    logic [4:0] col_n;
    logic [6:0] row;
    logic       code_err;
    logic       frame_done;

    exp_t exp_q[$];
    vec_t vecs[14];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_err;

    always #5 clock = ~clock;

    matrix_scan_ctrl #(
        .PRESCALE    (P),
        .BLANK_CYCLES(1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .code_in   (code_in),
        .col_n     (col_n),
        .row       (row),
        .code_err  (code_err),
        .frame_done(frame_done)
    );

    function automatic exp_t idle_exp(input logic err, input string tag);
        exp_t e;
        e.col_n = 5'b11111;
        e.row   = 7'h00;
        e.err   = err;
        e.fd    = 1'b0;
        e.tag   = tag;
        return e;
    endfunction

    // Expected outputs for cycle idx of a frame showing glyph g.
    function automatic exp_t frame_exp(input logic [34:0] g, input logic err, input int idx,
                                       input string tag);
        exp_t e;
        int k = idx / CP;
        int j = idx % CP;
        e.tag = tag;
        e.err = err;
        e.fd  = (k == 4) && (j == P - 1);
        if (j < P) begin
            e.col_n = ~(5'b00001 << k);
            e.row   = g[(4 - k) * 7 +: 7];
        end else begin
            e.col_n = 5'b11111;
            e.row   = 7'h00;
        end
        return e;
    endfunction

    // Inputs set by the caller are applied at the next edge; e is what must show after it.
    task automatic cyc(input exp_t e);
        @(posedge clock);
        #1;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({col_n, row, code_err, frame_done} === {e.col_n, e.row, e.err, e.fd}) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got col_n=%b row=%h err=%b fd=%b, want col_n=%b row=%h err=%b fd=%b",
                         e.tag, col_n, row, code_err, frame_done, e.col_n, e.row, e.err, e.fd);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{5'b11000, G0, 1'b0};
        vecs[1]  = '{5'b00011, G1, 1'b0};
        vecs[2]  = '{5'b00101, G2, 1'b0};
        vecs[3]  = '{5'b00110, G3, 1'b0};
        vecs[4]  = '{5'b01001, G4, 1'b0};
        vecs[5]  = '{5'b01010, G5, 1'b0};
        vecs[6]  = '{5'b00111, GE, 1'b1};
        vecs[7]  = '{5'b01100, G6, 1'b0};
        vecs[8]  = '{5'b10001, G7, 1'b0};
        vecs[9]  = '{5'b00001, GE, 1'b1};
        vecs[10] = '{5'b10010, G8, 1'b0};
        vecs[11] = '{5'b10100, G9, 1'b0};
        vecs[12] = '{5'b00000, GE, 1'b1};
        vecs[13] = '{5'b11110, GE, 1'b1};

        reset   = 1'b1;
        enable  = 1'b1;
        load    = 1'b0;
        code_in = 5'b00000;
        cyc(idle_exp(1'b0, "reset0"));
        cyc(idle_exp(1'b0, "reset1"));
        if ({col_n, row, code_err, frame_done} !== {5'b11111, 7'h00, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: col_n=%b row=%h err=%b fd=%b", col_n, row, code_err,
                     frame_done);
        end
        reset = 1'b0;
        repeat (8) cyc(idle_exp(1'b0, "idle_noload"));

        prev_err = 1'b0;
        for (int v = 0; v < 14; v++) begin
            enable = 1'b0;
            cyc(idle_exp(prev_err, $sformatf("vec%0d_idle", v)));
            enable  = 1'b1;
            load    = 1'b1;
            code_in = vecs[v].code;
            cyc(frame_exp(vecs[v].glyph, vecs[v].err, 0, $sformatf("vec%0d_i0", v)));
            load = 1'b0;
            for (int i = 1; i <= FL; i++) begin
                cyc(frame_exp(vecs[v].glyph, vecs[v].err, i % FL, $sformatf("vec%0d_i%0d", v, i)));
            end
            prev_err = vecs[v].err;
        end

        // Mid-frame loads only reach the display at the next frame.
        enable = 1'b0;
        cyc(idle_exp(prev_err, "tear_idle"));
        enable = 1'b1;
        for (int i = 0; i < 2 * FL; i++) begin
            load    = (i == 0) || (i == CP + 1) || (i == 2 * CP + 1);
            code_in = (i == 2 * CP + 1) ? 5'b00011 : 5'b11000;
            cyc(frame_exp((i < FL) ? G0 : G1, 1'b0, i % FL, $sformatf("tear_i%0d", i)));
        end
        load = 1'b0;

        // Load on the frame_done cycle shows on the very next frame.
        for (int i = 0; i < 2 * FL; i++) begin
            load    = (i == FD + 1);
            code_in = 5'b00101;
            cyc(frame_exp((i < FL) ? G1 : G2, 1'b0, i % FL, $sformatf("bfwd_i%0d", i)));
        end
        load = 1'b0;

        for (int i = 0; i < 6; i++) cyc(frame_exp(G2, 1'b0, i, $sformatf("en_run_i%0d", i)));
        enable = 1'b0;
        cyc(idle_exp(1'b0, "en_drop"));
        enable = 1'b1;
        for (int i = 0; i < FL; i++) cyc(frame_exp(G2, 1'b0, i, $sformatf("en_restart_i%0d", i)));

        // Load coinciding with enable falling is still captured.
        enable  = 1'b0;
        load    = 1'b1;
        code_in = 5'b01001;
        cyc(idle_exp(1'b0, "ld_dis"));
        load = 1'b0;
        cyc(idle_exp(1'b0, "ld_dis_idle"));
        enable = 1'b1;
        for (int i = 0; i < FL; i++) cyc(frame_exp(G4, 1'b0, i, $sformatf("ld_dis_i%0d", i)));

        for (int i = 0; i < 4; i++) cyc(frame_exp(G4, 1'b0, i, $sformatf("pre_rst_i%0d", i)));
        reset = 1'b1;
        cyc(idle_exp(1'b0, "rst_mid"));
        reset = 1'b0;
        repeat (6) cyc(idle_exp(1'b0, "rst_unloaded"));

        @(negedge clock);
        #1;
        if ((n_pass != n_checks) || (n_checks < 12)) begin
            $display("FAIL summary: %0d/%0d checks passed", n_pass, n_checks);
            $fatal(1);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
